// File: rtl/scalar_mul_acc.sv
// ============================================================================
//  scalar_mul_acc : group accumulator behind the ScalarMul pipeline. It is
//  followed by a result FIFO and a valid/ready output.
//  Optional macro SCALAR_MUL_ACC_SAT_EN: saturating sums plus the sat port.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module scalar_mul_acc #(
  parameter int DATA_W     = 16,
  parameter int ACC_W      = 40,
  parameter int PIPE_LAT   = 90,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_last,
  input  logic [DATA_W-1:0] prod,
  output logic [ACC_W-1:0]  out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow,
  output logic              busy
`ifdef SCALAR_MUL_ACC_SAT_EN
  ,
  output logic              sat
`endif
);

  localparam int              c_ADDR_W  = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  // ---------------------------------------------------------------- delay line
  logic [PIPE_LAT-1:0] r_dly_valid;
  logic [PIPE_LAT-1:0] r_dly_last;
  logic                w_tap_valid;
  logic                w_tap_last;

  generate
    if (PIPE_LAT > 1) begin : g_dly_shift
      always_ff @(posedge clock) begin
        if (reset) begin
          r_dly_valid <= '0;
          r_dly_last  <= '0;
        end else begin
          r_dly_valid <= {r_dly_valid[PIPE_LAT-2:0], in_valid};
          r_dly_last  <= {r_dly_last[PIPE_LAT-2:0], in_valid & in_last};
        end
      end
    end else begin : g_dly_single
      always_ff @(posedge clock) begin
        if (reset) begin
          r_dly_valid <= '0;
          r_dly_last  <= '0;
        end else begin
          r_dly_valid[0] <= in_valid;
          r_dly_last[0]  <= in_valid & in_last;
        end
      end
    end
  endgenerate

  assign w_tap_valid = r_dly_valid[PIPE_LAT-1];
  assign w_tap_last  = r_dly_last[PIPE_LAT-1];

  // --------------------------------------------------------------- accumulate
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_first;
  logic [ACC_W-1:0] w_base;
  logic [ACC_W-1:0] w_prod_ext;
  logic [ACC_W-1:0] w_sum;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_grp_sat_next;

  assign w_base     = r_first ? '0 : r_acc;
  assign w_prod_ext = {{(ACC_W-DATA_W){prod[DATA_W-1]}}, prod};
  assign w_cnt_next = r_first ? CNT_W'(1)
                    : ((r_cnt == c_CNT_MAX) ? c_CNT_MAX : r_cnt + 1'b1);

`ifdef SCALAR_MUL_ACC_SAT_EN
  logic [ACC_W:0] w_wide;
  logic           w_clamp;
  logic           r_grp_sat;

  // One guard bit: the sum overflowed when it disagrees with the MSB below it.
  assign w_wide  = {w_base[ACC_W-1], w_base} + {w_prod_ext[ACC_W-1], w_prod_ext};
  assign w_clamp = w_wide[ACC_W] ^ w_wide[ACC_W-1];
  assign w_sum   = !w_clamp ? w_wide[ACC_W-1:0]
                 : (w_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                  : {1'b0, {(ACC_W-1){1'b1}}});
  assign w_grp_sat_next = (r_first ? 1'b0 : r_grp_sat) | w_clamp;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_grp_sat <= 1'b0;
    end else if (w_tap_valid) begin
      r_grp_sat <= w_grp_sat_next;
    end
  end
`else
  assign w_sum          = w_base + w_prod_ext;
  assign w_grp_sat_next = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_first <= 1'b1;
    end else if (w_tap_valid) begin
      r_acc   <= w_sum;
      r_cnt   <= w_cnt_next;
      r_first <= w_tap_last;
    end
  end

  // -------------------------------------------------------------- result FIFO
  logic [ACC_W-1:0]  r_mem_data [FIFO_DEPTH];
  logic [CNT_W-1:0]  r_mem_cnt  [FIFO_DEPTH];
  logic              r_mem_sat  [FIFO_DEPTH];
  logic [c_ADDR_W:0] r_wr_ptr;
  logic [c_ADDR_W:0] r_rd_ptr;
  logic              r_overflow;
  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_wr_en;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]) &&
                   (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]);
  assign w_push  = w_tap_valid & w_tap_last;
  assign w_pop   = !w_empty & out_ready;
  // A simultaneous pop frees the slot the push needs, so a full FIFO still accepts.
  assign w_wr_en = w_push & (!w_full | w_pop);

  always_ff @(posedge clock) begin
    if (w_wr_en) begin
      r_mem_data[r_wr_ptr[c_ADDR_W-1:0]] <= w_sum;
      r_mem_cnt[r_wr_ptr[c_ADDR_W-1:0]]  <= w_cnt_next;
      r_mem_sat[r_wr_ptr[c_ADDR_W-1:0]]  <= w_grp_sat_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_wr_en) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------- outputs
  assign out_valid = !w_empty;
  assign out_data  = w_empty ? '0 : r_mem_data[r_rd_ptr[c_ADDR_W-1:0]];
  assign out_count = w_empty ? '0 : r_mem_cnt[r_rd_ptr[c_ADDR_W-1:0]];
  assign overflow  = r_overflow;
  assign busy      = (|r_dly_valid) | ~r_first;

`ifdef SCALAR_MUL_ACC_SAT_EN
  assign sat = w_empty ? 1'b0 : r_mem_sat[r_rd_ptr[c_ADDR_W-1:0]];
`else
  logic w_unused_sat;
  assign w_unused_sat = r_mem_sat[0];
`endif

endmodule

`default_nettype wire
